// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI line-read arbiter.
// Round-robin arbitration is enabled with the AXI_RD_ARB_RR_EN macro.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } arb_state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [7:0] LEN_LINE   = 8'd15;
   localparam logic [2:0] SIZE_WORD  = 3'd2;

   localparam int REQ_DCACHE   = 0;
   localparam int REQ_ICACHE   = 1;
   localparam int REQ_UNCACHED = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: round-robin after i_last when AXI_RD_ARB_RR_EN
// is defined, otherwise a lowest-index-wins priority encoder.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last,
   output logic [ID_W-1:0]    o_win,
   output logic               o_found
);

`ifdef AXI_RD_ARB_RR_EN
   int w_dist;
   int w_best;

   // Distance 0 is the requester right after i_last; the closest set bit wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      o_win   = '0;
      o_found = 1'b0;
      w_best  = NUM_REQ;
      w_dist  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + 2 * NUM_REQ - int'(i_last) - 1) % NUM_REQ;
         if (i_req[i] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_win   = ID_W'(i);
            o_found = 1'b1;
         end
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = ^i_last;

   always_comb begin
      o_win   = '0;
      o_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_win   = ID_W'(i);
            o_found = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the bridge's single line-read port among NUM_REQ requesters.
// Define AXI_RD_ARB_RR_EN for round-robin; default is fixed priority (index 0 first).
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 512,
   parameter int ID_W    = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]  req_len,
   input  logic [NUM_REQ*3-1:0]  req_size,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [LINE_W-1:0]     req_rdata,
   output logic [ADDR_W-1:0]     m_raddr,
   output logic [7:0]            m_rlen,
   output logic [2:0]            m_rsize,
   output logic                  m_rvalid,
   input  logic [LINE_W-1:0]     m_rdata,
   input  logic                  m_rready,
   output logic [ID_W-1:0]       grant_id,
   output logic                  busy
);

   arb_state_e        r_state;
   logic [ADDR_W-1:0] r_raddr;
   logic [7:0]        r_rlen;
   logic [2:0]        r_rsize;
   logic [ID_W-1:0]   r_grant_id;
   logic              r_rvalid;
   logic              r_busy;

   logic [ID_W-1:0]   w_win;
   logic              w_found;
   logic [ID_W-1:0]   w_last;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [7:0]        w_sel_len;
   logic [2:0]        w_sel_size;
   logic              w_done;

`ifdef AXI_RD_ARB_RR_EN
   logic [ID_W-1:0]   r_last_grant;
   assign w_last = r_last_grant;
`else
   assign w_last = '0;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req   (req_valid),
      .i_last  (w_last),
      .o_win   (w_win),
      .o_found (w_found)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_len  = '0;
      w_sel_size = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == ID_W'(i)) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_len  = req_len[i*8 +: 8];
            w_sel_size = req_size[i*3 +: 3];
         end
      end
   end

   // Completion is gated by reset so an aborted transfer never pulses req_ready.
   assign w_done    = r_rvalid && m_rready && aresetn;
   assign m_rvalid  = r_rvalid && !m_rready;
   assign req_ready = w_done ? (NUM_REQ'(1) << r_grant_id) : '0;
   assign req_rdata = m_rdata;
   assign m_raddr   = r_raddr;
   assign m_rlen    = r_rlen;
   assign m_rsize   = r_rsize;
   assign grant_id  = r_grant_id;
   assign busy      = r_busy;

   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      if (!aresetn) begin
         r_state      <= IDLE;
         r_raddr      <= '0;
         r_rlen       <= '0;
         r_rsize      <= '0;
         r_grant_id   <= '0;
         r_rvalid     <= 1'b0;
         r_busy       <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
         r_last_grant <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_raddr    <= w_sel_addr;
                  r_rlen     <= w_sel_len;
                  r_rsize    <= w_sel_size;
                  r_grant_id <= w_win;
                  r_rvalid   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= GRANT;
               end
            end
            GRANT: begin
               if (m_rready) begin
`ifdef AXI_RD_ARB_RR_EN
                  r_last_grant <= r_grant_id;
`endif
                  r_grant_id <= '0;
                  r_rvalid   <= 1'b0;
                  r_state    <= COOL;
               end
            end
            COOL: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_rvalid <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter against a queue-level
// arbitration model; honours AXI_RD_ARB_RR_EN the same way the design does.
module tb_axi_rd_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 512;
   localparam int ID_W    = 2;

   typedef logic [LINE_W-1:0] word_t;

   logic                      aclk;
   logic                      aresetn;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*8-1:0]      req_len;
   logic [NUM_REQ*3-1:0]      req_size;
   logic [NUM_REQ-1:0]        req_ready;
   logic [LINE_W-1:0]         req_rdata;
   logic [ADDR_W-1:0]         m_raddr;
   logic [7:0]                m_rlen;
   logic [2:0]                m_rsize;
   logic                      m_rvalid;
   logic [LINE_W-1:0]         m_rdata;
   logic                      m_rready;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   axi_rd_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .LINE_W  (LINE_W),
      .ID_W    (ID_W)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_size  (req_size),
      .req_ready (req_ready),
      .req_rdata (req_rdata),
      .m_raddr   (m_raddr),
      .m_rlen    (m_rlen),
      .m_rsize   (m_rsize),
      .m_rvalid  (m_rvalid),
      .m_rdata   (m_rdata),
      .m_rready  (m_rready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int unsigned cycle = 0;
   always @(posedge aclk) cycle <= cycle + 1;

   int total = 0;
   int bad   = 0;

   // Model state: pending requesters, their current request fields, last winner.
   logic [NUM_REQ-1:0] pend;
   logic [ADDR_W-1:0]  a_addr [NUM_REQ];
   logic [7:0]         a_len  [NUM_REQ];
   logic [2:0]         a_size [NUM_REQ];
   int                 last;
   int unsigned        done_cyc;

   task automatic check(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int lst);
      int idx;
`ifdef AXI_RD_ARB_RR_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (lst + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
`else
      idx = lst;
      for (int i = 0; i < NUM_REQ; i++)
         if (v[i]) return i;
`endif
      return -1;
   endfunction

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = a_addr[i];
         req_len[i*8 +: 8]            = a_len[i];
         req_size[i*3 +: 3]           = a_size[i];
      end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < NUM_REQ; i++) begin
         a_addr[i] = $urandom;
         a_len[i]  = 8'($urandom_range(0, 255));
         a_size[i] = 3'($urandom_range(0, 7));
      end
   endtask

   function automatic word_t rand_word();
      word_t x;
      for (int i = 0; i < LINE_W / 32; i++) x[i*32 +: 32] = $urandom;
      return x;
   endfunction

   task automatic do_reset();
      aresetn  = 1'b0;
      pend     = '0;
      m_rready = 1'b0;
      m_rdata  = '0;
      drive();
      step();
      step();
      check("rst_rvalid", word_t'(m_rvalid), word_t'(0));
      check("rst_raddr", word_t'(m_raddr), word_t'(0));
      check("rst_rlen", word_t'(m_rlen), word_t'(0));
      check("rst_rsize", word_t'(m_rsize), word_t'(0));
      check("rst_ready", word_t'(req_ready), word_t'(0));
      check("rst_grant", word_t'(grant_id), word_t'(0));
      check("rst_busy", word_t'(busy), word_t'(0));
      aresetn  = 1'b1;
      last     = NUM_REQ - 1;
      done_cyc = 0;
   endtask

   // One full transaction starting in IDLE and ending back in IDLE.
   task automatic run_txn(input logic [NUM_REQ-1:0] add, input int hold,
                          input bit drop_mid, input bit reassert, input word_t data);
      int w;
      logic [ADDR_W-1:0] ea;
      logic [7:0]        el;
      logic [2:0]        es;
      pend = pend | add;
      if (pend == '0) pend[0] = 1'b1;
      drive();
      #1;
      check("idle_rvalid", word_t'(m_rvalid), word_t'(0));
      check("idle_busy", word_t'(busy), word_t'(0));
      w  = model_pick(pend, last);
      ea = a_addr[w];
      el = a_len[w];
      es = a_size[w];
      step();
      check("issue_rvalid", word_t'(m_rvalid), word_t'(1));
      check("issue_grant", word_t'(grant_id), word_t'(w));
      check("issue_raddr", word_t'(m_raddr), word_t'(ea));
      check("issue_rlen", word_t'(m_rlen), word_t'(el));
      check("issue_rsize", word_t'(m_rsize), word_t'(es));
      check("issue_busy", word_t'(busy), word_t'(1));
      check("issue_ready", word_t'(req_ready), word_t'(0));
      if (done_cyc != 0)
         check("spacing_ge3", word_t'(cycle - done_cyc >= 3), word_t'(1));
      for (int h = 0; h < hold; h++) begin
         if (drop_mid) begin
            pend[w] = 1'b0;
            rand_fields();
            drive();
         end
         step();
         check("hold_raddr", word_t'(m_raddr), word_t'(ea));
         check("hold_rlen", word_t'(m_rlen), word_t'(el));
         check("hold_rvalid", word_t'(m_rvalid), word_t'(1));
         check("hold_ready", word_t'(req_ready), word_t'(0));
      end
      m_rdata  = data;
      m_rready = 1'b1;
      #1;
      check("done_ready", word_t'(req_ready), word_t'(1) << w);
      check("done_rdata", req_rdata, data);
      check("done_rvalid", word_t'(m_rvalid), word_t'(0));
      done_cyc = cycle;
`ifdef AXI_RD_ARB_RR_EN
      last = w;
`endif
      step();
      m_rready = 1'b0;
      #1;
      check("cool_rvalid", word_t'(m_rvalid), word_t'(0));
      check("cool_busy", word_t'(busy), word_t'(1));
      check("cool_ready", word_t'(req_ready), word_t'(0));
      pend[w] = reassert;
      drive();
      step();
      check("back_idle_busy", word_t'(busy), word_t'(0));
      check("back_idle_rvalid", word_t'(m_rvalid), word_t'(0));
      check("back_idle_grant", word_t'(grant_id), word_t'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      rand_fields();
      do_reset();

      // Spurious completion while idle must be ignored.
      m_rdata  = rand_word();
      m_rready = 1'b1;
      #1;
      check("spur_ready", word_t'(req_ready), word_t'(0));
      check("spur_rvalid", word_t'(m_rvalid), word_t'(0));
      step();
      check("spur_busy", word_t'(busy), word_t'(0));
      m_rready = 1'b0;
      step();
      check("spur_idle_rvalid", word_t'(m_rvalid), word_t'(0));

      // Single icache request with known address and data.
      a_addr[1] = 32'h1C00_0040;
      a_len[1]  = 8'd15;
      a_size[1] = 3'd2;
      run_txn(3'b010, 0, 1'b0, 1'b0, {16{32'hA5A5_A5A5}});

      // Contention with every requester re-asserting in COOL.
      do_reset();
      rand_fields();
      for (int t = 0; t < 3; t++) run_txn(3'b111, 1, 1'b0, 1'b1, rand_word());
      for (int t = 0; t < 3; t++) run_txn(3'b000, 0, 1'b0, 1'b0, rand_word());

      // Winner withdraws mid-GRANT while request fields churn.
      rand_fields();
      run_txn(3'b001, 3, 1'b1, 1'b0, rand_word());

      // Reset while a transfer is outstanding.
      pend = 3'b001;
      drive();
      step();
      check("rg_rvalid", word_t'(m_rvalid), word_t'(1));
      aresetn = 1'b0;
      #1;
      check("rg_ready_in_rst", word_t'(req_ready), word_t'(0));
      step();
      aresetn = 1'b1;
      pend    = '0;
      drive();
      #1;
      check("rg_after_rvalid", word_t'(m_rvalid), word_t'(0));
      check("rg_after_grant", word_t'(grant_id), word_t'(0));
      check("rg_after_ready", word_t'(req_ready), word_t'(0));
      check("rg_after_busy", word_t'(busy), word_t'(0));
      last     = NUM_REQ - 1;
      done_cyc = 0;
      run_txn(3'b110, 1, 1'b0, 1'b0, rand_word());
      while (pend != '0) run_txn(3'b000, 0, 1'b0, 1'b0, rand_word());

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         bit drop;
         int hold;
         rand_fields();
         drop = ($urandom_range(0, 3) == 0);
         hold = $urandom_range(0, 3);
         if (drop && hold == 0) hold = 1;
         run_txn(NUM_REQ'($urandom_range(0, 7)), hold, drop,
                 ($urandom_range(0, 3) == 0), rand_word());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
